muladd_seq: RTL and testbench

Single-clock scheduler for the multiply-add PE array. It accepts a job (K operand vectors per dot product, T dot products per job) and gates operand-vector handshakes from the input buffer into the PE. It marks the first and last beat of each dot product, waits for the PE result and presents it on a valid/ready output. It sits between the load buffer and the PE on the clk_pe domain.

---
 rtl/muladd_pkg.sv | 20 ++
 rtl/muladd_seq.sv | 171 +++++++++++++++++
 tb/tb_muladd_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muladd_pkg.sv
// Shared types and sizing helpers for the multiply-add PE scheduler.
package muladd_pkg;

    localparam int DW_DEF    = 32;
    localparam int K_MAX_DEF = 256;
    localparam int T_MAX_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    // Width of a counter that must be able to hold the value max_v itself.
    function automatic int cnt_w(input int max_v);
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/muladd_seq.sv
// Dot-product job scheduler: gates operand beats into the PE, captures the result.
// Optional stall counter output perf_stall_o is built when MULADD_SEQ_STALL_CNT_EN is defined.
module muladd_seq
    import muladd_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int T_MAX = T_MAX_DEF
) (
    input  logic                      clk_pe,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [cnt_w(K_MAX)-1:0]   cfg_k_i,
    input  logic [cnt_w(T_MAX)-1:0]   cfg_t_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    input  logic                      vec_valid_i,
    output logic                      vec_ready_o,
    output logic                      pe_en_o,
    output logic                      pe_clr_o,
    output logic                      pe_last_o,
    input  logic                      pe_result_valid_i,
    input  logic [DW-1:0]             pe_result_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
`ifdef MULADD_SEQ_STALL_CNT_EN
    output logic [31:0]               perf_stall_o,
`endif
    output logic [DW-1:0]             result_payload_o
);

    localparam int KW = cnt_w(K_MAX);
    localparam int TW = cnt_w(T_MAX);

    seq_state_e      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]   tile_cnt_q, tile_cnt_d;
    logic [DW-1:0]   payload_q, payload_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            start_acc;
    logic            vec_ready;
    logic            last_beat;

    assign start_acc = (state_q == IDLE) && start_i && (cfg_k_i != '0) && (cfg_t_i != '0);
    assign vec_ready = (state_q == ISSUE);
    assign last_beat = (beat_cnt_q == k_q - 1'b1);

    always_comb begin
        // NOTE: every next-state variable gets a default first so no latch is inferred.
        state_d    = state_q;
        k_d        = k_q;
        t_d        = t_q;
        beat_cnt_d = beat_cnt_q;
        tile_cnt_d = tile_cnt_q;
        payload_d  = payload_q;
        err_d      = err_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    k_d        = cfg_k_i;
                    t_d        = cfg_t_i;
                    beat_cnt_d = '0;
                    tile_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (vec_valid_i) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pe_result_valid_i) begin
                    payload_d = pe_result_i;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (result_ready_i) begin
                    tile_cnt_d = tile_cnt_q + 1'b1;
                    if (tile_cnt_q == t_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stray strobe wins over the clear of an accepted start in the same cycle.
        if (pe_result_valid_i && (state_q != DRAIN)) begin
            err_d = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            t_q        <= '0;
            beat_cnt_q <= '0;
            tile_cnt_q <= '0;
            payload_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            t_q        <= t_d;
            beat_cnt_q <= beat_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            payload_q  <= payload_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

`ifdef MULADD_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_evt;

    assign stall_evt = ((state_q == ISSUE) && !vec_valid_i) ||
                       ((state_q == OUT) && !result_ready_i);

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pe or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign perf_stall_o = stall_q;
`endif

    // Beat qualifiers are combinational so the PE samples them with the operand data.
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign vec_ready_o      = vec_ready;
    assign pe_en_o          = vec_valid_i & vec_ready;
    assign pe_clr_o         = pe_en_o & (beat_cnt_q == '0);
    assign pe_last_o        = pe_en_o & last_beat;
    assign result_valid_o   = (state_q == OUT);
    assign result_payload_o = payload_q;

endmodule

// File: tb/tb_muladd_seq.sv
// Directed testbench for muladd_seq with a fixed-latency PE model.
module tb_muladd_seq;

    localparam int DW     = 32;
    localparam int KW     = 9;
    localparam int TW     = 9;
    localparam int PE_LAT = 3;

    logic            clk_pe;
    logic            rst_n;
    logic            start_i;
    logic [KW-1:0]   cfg_k_i;
    logic [TW-1:0]   cfg_t_i;
    logic            busy_o, done_o, err_o;
    logic            vec_valid_i, vec_ready_o;
    logic            pe_en_o, pe_clr_o, pe_last_o;
    logic            pe_result_valid_i;
    logic [DW-1:0]   pe_result_i;
    logic            result_valid_o, result_ready_i;
    logic [DW-1:0]   result_payload_o;
`ifdef MULADD_SEQ_STALL_CNT_EN
    logic [31:0]     perf_stall_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    muladd_seq dut (
        .clk_pe            (clk_pe),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .cfg_k_i           (cfg_k_i),
        .cfg_t_i           (cfg_t_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .vec_valid_i       (vec_valid_i),
        .vec_ready_o       (vec_ready_o),
        .pe_en_o           (pe_en_o),
        .pe_clr_o          (pe_clr_o),
        .pe_last_o         (pe_last_o),
        .pe_result_valid_i (pe_result_valid_i),
        .pe_result_i       (pe_result_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
`ifdef MULADD_SEQ_STALL_CNT_EN
        .perf_stall_o      (perf_stall_o),
`endif
        .result_payload_o  (result_payload_o)
    );

    initial begin
        clk_pe = 1'b0;
        forever #5 clk_pe = ~clk_pe;
    end

    // PE model: result strobe PE_LAT edges after the edge that takes the last beat.
    logic          pe_model_v = 1'b0;
    logic          inj_v      = 1'b0;
    logic [DW-1:0] pe_model_d = '0;
    logic [DW-1:0] pe_vals [4];
    int            pe_idx    = 0;
    bit            last_seen = 1'b0;
    int            pend      = 0;

    assign pe_result_valid_i = pe_model_v | inj_v;
    assign pe_result_i       = pe_model_d;

    always @(posedge clk_pe) begin
        if (rst_n && pe_en_o && pe_last_o) last_seen = 1'b1;
    end

    always @(negedge clk_pe) begin
        pe_model_v = 1'b0;
        if (!rst_n) begin
            pend      = 0;
            last_seen = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    pe_model_v = 1'b1;
                    pe_model_d = pe_vals[pe_idx % 4];
                    pe_idx++;
                end
            end
            if (last_seen) begin
                pend      = PE_LAT - 1;
                last_seen = 1'b0;
            end
        end
    end

    // Per-job observations collected by run_job and judged by each test task.
    int            j_en, j_en_err, j_clr_err, j_last_err, j_first_err;
    int            j_done, j_busy_err, j_drop_err, j_stable_err, j_rdy_out_err, j_stalls;
    bit            j_timeout;
    logic [DW-1:0] j_res [$];
    logic [31:0]   j_perf;

    task automatic run_job(input int k, input int t, input bit toggle, input int ready_delay,
                           input bit garble);
        int            beat = 0;
        int            out_wait = 0;
        bit            first = 1'b1;
        bit            vv = 1'b1;
        bit            prev_valid = 1'b0;
        bit            done_prev = 1'b0;
        bit            finished = 1'b0;
        logic [DW-1:0] held = '0;
        j_en = 0; j_en_err = 0; j_clr_err = 0; j_last_err = 0; j_first_err = 0;
        j_done = 0; j_busy_err = 0; j_drop_err = 0; j_stable_err = 0; j_rdy_out_err = 0;
        j_stalls = 0; j_timeout = 1'b0; j_perf = '0;
        j_res.delete();
        pe_idx = 0;
        @(negedge clk_pe);
        start_i = 1'b1; cfg_k_i = KW'(k); cfg_t_i = TW'(t);
        vec_valid_i = 1'b0; result_ready_i = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk_pe);
            if (done_prev) begin
                if (done_o !== 1'b0) j_drop_err++;
                finished = 1'b1;
            end else begin
                if (first && (busy_o !== 1'b1 || vec_ready_o !== 1'b1)) j_first_err++;
                first = 1'b0;
                if (done_o === 1'b1) begin
                    j_done++;
                    if (busy_o !== 1'b0) j_busy_err++;
`ifdef MULADD_SEQ_STALL_CNT_EN
                    j_perf = perf_stall_o;
`endif
                    done_prev = 1'b1;
                end
                start_i = garble && !done_prev;
                cfg_k_i = garble && !done_prev ? KW'(1) : KW'(k);
                cfg_t_i = garble && !done_prev ? TW'(1) : TW'(t);
                if (result_valid_o === 1'b1) begin
                    if (!prev_valid) begin
                        held = result_payload_o;
                        out_wait = 0;
                        j_res.push_back(result_payload_o);
                    end else if (result_payload_o !== held) begin
                        j_stable_err++;
                    end
                    if (vec_ready_o !== 1'b0) j_rdy_out_err++;
                    result_ready_i = (out_wait >= ready_delay);
                    out_wait++;
                end else begin
                    result_ready_i = 1'b0;
                end
                prev_valid = result_valid_o && !result_ready_i;
                if (toggle) begin
                    vec_valid_i = vv;
                    vv = ~vv;
                end else begin
                    vec_valid_i = 1'b1;
                end
                if (vec_ready_o && !vec_valid_i) j_stalls++;
                if (result_valid_o && !result_ready_i) j_stalls++;
                #1;
                if (pe_en_o !== (vec_valid_i & vec_ready_o)) j_en_err++;
                if (pe_en_o === 1'b1) begin
                    j_en++;
                    if (pe_clr_o !== (beat == 0)) j_clr_err++;
                    if (pe_last_o !== (beat == k - 1)) j_last_err++;
                    beat = (beat == k - 1) ? 0 : beat + 1;
                end else if (pe_clr_o !== 1'b0 || pe_last_o !== 1'b0) begin
                    j_clr_err++;
                end
            end
        end
        if (!finished) j_timeout = 1'b1;
        start_i = 1'b0; vec_valid_i = 1'b0; result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; cfg_k_i = '0; cfg_t_i = '0;
        vec_valid_i = 1'b0; result_ready_i = 1'b0;
        repeat (2) @(negedge clk_pe);
        vec_valid_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, done_o, err_o, vec_ready_o, pe_en_o, pe_clr_o, pe_last_o, result_valid_o} !== 8'h00)
            $display("FAIL reset_outputs: got %b want 00000000",
                     {busy_o, done_o, err_o, vec_ready_o, pe_en_o, pe_clr_o, pe_last_o, result_valid_o});
        else n_pass++;
        n_checks++;
        if (result_payload_o !== 32'h0)
            $display("FAIL reset_payload: got %h want 00000000", result_payload_o);
        else n_pass++;
        @(negedge clk_pe);
        vec_valid_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        pe_vals[0] = 32'h0000_1234;
        run_job(8, 1, 1'b0, 0, 1'b0);
        n_checks++;
        if (j_timeout !== 1'b0) $display("FAIL single_timeout: got %0d want 0", j_timeout); else n_pass++;
        n_checks++;
        if (j_first_err !== 0) $display("FAIL single_start_latency: got %0d errs want 0", j_first_err); else n_pass++;
        n_checks++;
        if (j_en !== 8) $display("FAIL single_en_beats: got %0d want 8", j_en); else n_pass++;
        n_checks++;
        if (j_clr_err + j_last_err + j_en_err !== 0)
            $display("FAIL single_clr_last: got %0d errs want 0", j_clr_err + j_last_err + j_en_err);
        else n_pass++;
        n_checks++;
        if (j_res.size() !== 1 || j_res[0] !== 32'h0000_1234)
            $display("FAIL single_payload: got n=%0d first=%h want n=1 00001234",
                     j_res.size(), (j_res.size() > 0) ? j_res[0] : 32'hx);
        else n_pass++;
        n_checks++;
        if (j_done !== 1 || j_drop_err !== 0)
            $display("FAIL single_done_pulse: got %0d pulses %0d long want 1 0", j_done, j_drop_err);
        else n_pass++;
        n_checks++;
        if (j_busy_err !== 0) $display("FAIL single_busy_fall: got %0d want 0", j_busy_err); else n_pass++;
    endtask

    task automatic test_backpressure();
        pe_vals[0] = 32'hA000_0001; pe_vals[1] = 32'hA000_0002; pe_vals[2] = 32'hA000_0003;
        run_job(4, 3, 1'b0, 5, 1'b1);
        n_checks++;
        if (j_timeout !== 1'b0) $display("FAIL bp_timeout: got %0d want 0", j_timeout); else n_pass++;
        n_checks++;
        if (j_en !== 12) $display("FAIL bp_en_beats: got %0d want 12", j_en); else n_pass++;
        n_checks++;
        if (j_clr_err + j_last_err !== 0) $display("FAIL bp_clr_last: got %0d errs want 0", j_clr_err + j_last_err); else n_pass++;
        n_checks++;
        if (j_stable_err !== 0) $display("FAIL bp_payload_stable: got %0d errs want 0", j_stable_err); else n_pass++;
        n_checks++;
        if (j_rdy_out_err !== 0) $display("FAIL bp_ready_in_out: got %0d errs want 0", j_rdy_out_err); else n_pass++;
        n_checks++;
        if (j_res.size() !== 3 || j_res[0] !== 32'hA000_0001 || j_res[1] !== 32'hA000_0002 ||
            j_res[2] !== 32'hA000_0003)
            $display("FAIL bp_result_order: got n=%0d want 3 results A0000001..A0000003", j_res.size());
        else n_pass++;
        n_checks++;
        if (j_done !== 1 || j_drop_err !== 0)
            $display("FAIL bp_done_pulse: got %0d pulses %0d long want 1 0", j_done, j_drop_err);
        else n_pass++;
    endtask

    task automatic test_toggle();
        pe_vals[0] = 32'h0BAD_F00D; pe_vals[1] = 32'h1234_5678;
        run_job(8, 2, 1'b1, 0, 1'b0);
        n_checks++;
        if (j_timeout !== 1'b0) $display("FAIL toggle_timeout: got %0d want 0", j_timeout); else n_pass++;
        n_checks++;
        if (j_en !== 16 || j_en_err !== 0)
            $display("FAIL toggle_en_beats: got %0d (%0d gating errs) want 16 (0)", j_en, j_en_err);
        else n_pass++;
        n_checks++;
        if (j_clr_err + j_last_err !== 0) $display("FAIL toggle_clr_last: got %0d errs want 0", j_clr_err + j_last_err); else n_pass++;
        n_checks++;
        if (j_res.size() !== 2 || j_res[1] !== 32'h1234_5678)
            $display("FAIL toggle_results: got n=%0d want 2 ending 12345678", j_res.size());
        else n_pass++;
`ifdef MULADD_SEQ_STALL_CNT_EN
        n_checks++;
        if (j_perf !== 32'(j_stalls)) $display("FAIL toggle_perf_stall: got %0d want %0d", j_perf, j_stalls); else n_pass++;
`endif
    endtask

    task automatic test_k1();
        pe_vals[0] = 32'h0000_0011; pe_vals[1] = 32'h0000_0022;
        run_job(1, 2, 1'b0, 1, 1'b0);
        n_checks++;
        if (j_en !== 2) $display("FAIL k1_en_beats: got %0d want 2", j_en); else n_pass++;
        n_checks++;
        if (j_clr_err + j_last_err !== 0) $display("FAIL k1_clr_last_coincide: got %0d errs want 0", j_clr_err + j_last_err); else n_pass++;
        n_checks++;
        if (j_res.size() !== 2 || j_res[0] !== 32'h11 || j_res[1] !== 32'h22 || j_done !== 1)
            $display("FAIL k1_results: got n=%0d done=%0d want 2 1", j_res.size(), j_done);
        else n_pass++;
    endtask

    task automatic test_bad_start_err();
        logic [DW-1:0] saved;
        saved = result_payload_o;
        @(negedge clk_pe); start_i = 1'b1; cfg_k_i = '0; cfg_t_i = TW'(2);
        @(negedge clk_pe); start_i = 1'b1; cfg_k_i = KW'(3); cfg_t_i = '0;
        n_checks++;
        if (busy_o !== 1'b0 || vec_ready_o !== 1'b0)
            $display("FAIL bad_start_k0: got busy=%b ready=%b want 0 0", busy_o, vec_ready_o);
        else n_pass++;
        @(negedge clk_pe); start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || vec_ready_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL bad_start_t0: got busy=%b ready=%b err=%b want 0 0 0", busy_o, vec_ready_o, err_o);
        else n_pass++;
        inj_v = 1'b1;
        @(negedge clk_pe); inj_v = 1'b0;
        repeat (3) @(negedge clk_pe);
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
        n_checks++;
        if (result_payload_o !== saved || busy_o !== 1'b0)
            $display("FAIL err_payload_kept: got %h busy=%b want %h 0", result_payload_o, busy_o, saved);
        else n_pass++;
        pe_vals[0] = 32'h0000_0C0C;
        run_job(2, 1, 1'b0, 0, 1'b0);
        n_checks++;
        if (err_o !== 1'b0 || j_done !== 1) $display("FAIL err_cleared: got err=%b done=%0d want 0 1", err_o, j_done); else n_pass++;
    endtask

    task automatic test_mid_reset();
        @(negedge clk_pe); start_i = 1'b1; cfg_k_i = KW'(8); cfg_t_i = TW'(1);
        @(negedge clk_pe); start_i = 1'b0; vec_valid_i = 1'b1;
        repeat (4) @(negedge clk_pe);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, err_o, vec_ready_o, pe_en_o, pe_clr_o, pe_last_o, result_valid_o} !== 8'h00 ||
            result_payload_o !== 32'h0)
            $display("FAIL midreset_outputs: got %b %h want 00000000 00000000",
                     {busy_o, done_o, err_o, vec_ready_o, pe_en_o, pe_clr_o, pe_last_o, result_valid_o},
                     result_payload_o);
        else n_pass++;
        @(negedge clk_pe); rst_n = 1'b1; vec_valid_i = 1'b0;
        pe_vals[0] = 32'h0000_0202;
        run_job(2, 1, 1'b0, 0, 1'b0);
        n_checks++;
        if (j_en !== 2 || j_clr_err + j_last_err !== 0 || j_res.size() !== 1 || j_res[0] !== 32'h202)
            $display("FAIL midreset_rerun: got en=%0d errs=%0d n=%0d want 2 0 1", j_en,
                     j_clr_err + j_last_err, j_res.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_toggle();
        test_k1();
        test_bad_start_err();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
